// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared constants for the MEM/WB pipeline register and its slot cells.
// Slot payload layout, MSB first:
//   valid | wb_en | mem_read_en | alu_result | mem_read_value | dest
// The three control bits sit at the top so a slot can clear them as one group.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned DEST_W_DEF = 4;
    localparam int unsigned DEPTH_DEF  = 1;
    localparam int unsigned DEPTH_MAX  = 4;

    // valid, wb_en, mem_read_en
    localparam int unsigned N_CTRL = 3;

    // Payload width for the default field widths
    localparam int unsigned SLOT_W = N_CTRL + 2 * DATA_W_DEF + DEST_W_DEF;

    // Payload width for arbitrary field widths
    function automatic int unsigned slot_w(input int unsigned data_w,
                                           input int unsigned dest_w);
        return N_CTRL + 2 * data_w + dest_w;
    endfunction

endpackage

// File: rtl/mem_wb_slot.sv
// -----------------------------------------------------------------------------
// mem_wb_slot
// One register slot of the MEM/WB pipe. Captures i_d when i_load is high;
// i_clear_ctrl zeroes the control group (top N_CTRL bits) on that capture
// while the data fields still load.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   i_load        capture enable (low = hold)
//   i_clear_ctrl  load a bubble: control bits forced to 0
//   i_d           incoming payload
//   o_q           registered payload
// -----------------------------------------------------------------------------
module mem_wb_slot
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = SLOT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_clear_ctrl,
    input  logic [PAYLOAD_W-1:0] i_d,
    output logic [PAYLOAD_W-1:0] o_q
);

    logic [PAYLOAD_W-1:0] r_q;

    // Payload register; control group masked on a bubble load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= {i_d[PAYLOAD_W-1 -: N_CTRL] & {N_CTRL{~i_clear_ctrl}},
                    i_d[PAYLOAD_W-N_CTRL-1:0]};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe_reg
// DEPTH-slot MEM/WB pipeline register with per-slot valid, stall (freeze)
// and bubble insertion (flush). Latency is DEPTH cycles. Every slot's
// dest and gated wb_en are exported for hazard/forwarding logic.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   freeze                hold every slot
//   flush                 clear control bits (all slots or slot 0, per FLUSH_ALL);
//                         overrides freeze
//   valid_in .. dest_in   payload from the MEM stage
//   valid .. dest         payload of the oldest slot (wb_en gated by valid)
//   slot_wb_en            per-slot valid & wb_en, bit 0 = youngest
//   slot_dest             per-slot dest, slot i at [i*DEST_W +: DEST_W]
//   busy                  any slot valid
// -----------------------------------------------------------------------------
module mem_wb_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned DEST_W    = DEST_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter bit          FLUSH_ALL = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    flush,
    input  logic                    valid_in,
    input  logic                    wb_en_in,
    input  logic                    mem_read_en_in,
    input  logic [DATA_W-1:0]       alu_result_in,
    input  logic [DATA_W-1:0]       mem_read_value_in,
    input  logic [DEST_W-1:0]       dest_in,
    output logic                    valid,
    output logic                    wb_en,
    output logic                    mem_read_en,
    output logic [DATA_W-1:0]       alu_result,
    output logic [DATA_W-1:0]       mem_read_value,
    output logic [DEST_W-1:0]       dest,
    output logic [DEPTH-1:0]        slot_wb_en,
    output logic [DEPTH*DEST_W-1:0] slot_dest,
    output logic                    busy
);

    localparam int unsigned PW      = slot_w(DATA_W, DEST_W);
    localparam int unsigned VALID_B = PW - 1;
    localparam int unsigned WBEN_B  = PW - 2;
    localparam int unsigned MRD_B   = PW - 3;
    localparam int unsigned ALU_LSB = DATA_W + DEST_W;
    localparam int unsigned MEM_LSB = DEST_W;

    if (DEPTH < 1 || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("mem_wb_pipe_reg: DEPTH must be in 1..4");
    end

    logic          w_load;
    logic [PW-1:0] w_in;
    logic [PW-1:0] w_q [DEPTH];
    logic [PW-1:0] w_last;
    logic [DEPTH-1:0] w_slot_valid;

    // Flush forces a capture even while frozen
    assign w_load = flush | ~freeze;
    assign w_in   = {valid_in, wb_en_in, mem_read_en_in,
                     alu_result_in, mem_read_value_in, dest_in};

    // Slot chain: slot 0 is fed by the inputs, slot i by slot i-1
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PW-1:0] w_d;
        logic          w_clear;

        if (i == 0) begin : g_head
            assign w_d = w_in;
        end else begin : g_chain
            assign w_d = w_q[i-1];
        end

        assign w_clear = flush & (FLUSH_ALL | (i == 0));

        mem_wb_slot #(
            .PAYLOAD_W (PW)
        ) u_slot (
            .clk          (clk),
            .rst_n        (rst),
            .i_load       (w_load),
            .i_clear_ctrl (w_clear),
            .i_d          (w_d),
            .o_q          (w_q[i])
        );

        assign w_slot_valid[i]                 = w_q[i][VALID_B];
        assign slot_wb_en[i]                   = w_q[i][VALID_B] & w_q[i][WBEN_B];
        assign slot_dest[i*DEST_W +: DEST_W]   = w_q[i][DEST_W-1:0];
    end

    // Outputs taken straight from the oldest slot
    assign w_last         = w_q[DEPTH-1];
    assign valid          = w_last[VALID_B];
    assign wb_en          = w_last[VALID_B] & w_last[WBEN_B];
    assign mem_read_en    = w_last[MRD_B];
    assign alu_result     = w_last[ALU_LSB +: DATA_W];
    assign mem_read_value = w_last[MEM_LSB +: DATA_W];
    assign dest           = w_last[DEST_W-1:0];
    assign busy           = |w_slot_valid;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_pipe_reg
// Five instances share one input stream:
//   inst0 DEPTH1 FA1, inst1 DEPTH2 FA1, inst2 DEPTH2 FA0,
//   inst3 DEPTH3 FA1, inst4 DEPTH4 FA0
// A reference model holds each instance's slots as a plain array of
// payload records and applies the shift/hold/bubble rules each edge.
// -----------------------------------------------------------------------------
module tb_mem_wb_pipe_reg;

    localparam int NI = 5;

    typedef struct packed {
        logic        v;
        logic        w;
        logic        m;
        logic [31:0] a;
        logic [31:0] r;
        logic [3:0]  d;
    } pl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic        wb_en_in = 1'b0;
    logic        mem_read_en_in = 1'b0;
    logic [31:0] alu_result_in = '0;
    logic [31:0] mem_read_value_in = '0;
    logic [3:0]  dest_in = '0;

    logic [91:0] obs [NI];
    pl_t         mdl [NI][4];
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    function automatic int unsigned dep_of(input int k);
        return (k == 0) ? 1 : (k < 3) ? 2 : (k == 3) ? 3 : 4;
    endfunction

    function automatic bit fa_of(input int k);
        return !(k == 2 || k == 4);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned D  = dep_of(g);
        localparam bit          FA = fa_of(g);
        logic          o_valid, o_wb, o_mrd, o_busy;
        logic [31:0]   o_alu, o_mem;
        logic [3:0]    o_dest;
        logic [D-1:0]  o_swb;
        logic [D*4-1:0] o_sd;

        mem_wb_pipe_reg #(
            .DATA_W    (32),
            .DEST_W    (4),
            .DEPTH     (D),
            .FLUSH_ALL (FA)
        ) u_dut (
            .clk               (clk),
            .rst               (rst),
            .freeze            (freeze),
            .flush             (flush),
            .valid_in          (valid_in),
            .wb_en_in          (wb_en_in),
            .mem_read_en_in    (mem_read_en_in),
            .alu_result_in     (alu_result_in),
            .mem_read_value_in (mem_read_value_in),
            .dest_in           (dest_in),
            .valid             (o_valid),
            .wb_en             (o_wb),
            .mem_read_en       (o_mrd),
            .alu_result        (o_alu),
            .mem_read_value    (o_mem),
            .dest              (o_dest),
            .slot_wb_en        (o_swb),
            .slot_dest         (o_sd),
            .busy              (o_busy)
        );

        assign obs[g] = {o_valid, o_wb, o_mrd, o_alu, o_mem, o_dest,
                         4'(o_swb), 16'(o_sd), o_busy};
    end

    // Expected visible outputs of instance k from its model slots
    function automatic logic [91:0] exp_vec(input int k);
        pl_t         last;
        logic [3:0]  swb;
        logic [15:0] sd;
        logic        b;
        swb  = '0;
        sd   = '0;
        b    = 1'b0;
        last = mdl[k][dep_of(k)-1];
        for (int i = 0; i < int'(dep_of(k)); i++) begin
            swb[i]        = mdl[k][i].v & mdl[k][i].w;
            sd[i*4 +: 4]  = mdl[k][i].d;
            b             = b | mdl[k][i].v;
        end
        return {last.v, last.v & last.w, last.m, last.a, last.r, last.d, swb, sd, b};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < 4; i++)
                mdl[k][i] = '0;
    endtask

    // Apply one clock edge's rules to every modelled instance
    task automatic model_edge();
        pl_t in;
        in = {valid_in, wb_en_in, mem_read_en_in, alu_result_in, mem_read_value_in, dest_in};
        for (int k = 0; k < NI; k++) begin
            if (flush || !freeze) begin
                for (int i = 3; i > 0; i--) mdl[k][i] = mdl[k][i-1];
                mdl[k][0] = in;
                if (flush)
                    for (int i = 0; i < 4; i++)
                        if (fa_of(k) || i == 0) begin
                            mdl[k][i].v = 1'b0;
                            mdl[k][i].w = 1'b0;
                            mdl[k][i].m = 1'b0;
                        end
            end
        end
    endtask

    task automatic drive(input pl_t p, input logic frz, input logic fl);
        valid_in          = p.v;
        wb_en_in          = p.w;
        mem_read_en_in    = p.m;
        alu_result_in     = p.a;
        mem_read_value_in = p.r;
        dest_in           = p.d;
        freeze            = frz;
        flush             = fl;
    endtask

    function automatic pl_t rand_pl();
        pl_t p;
        p.v = 1'($urandom_range(0, 1));
        p.w = 1'($urandom_range(0, 1));
        p.m = 1'($urandom_range(0, 1));
        p.a = $urandom;
        p.r = $urandom;
        p.d = 4'($urandom);
        return p;
    endfunction

    // Advance one edge and land 1 time unit after it
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        pl_t p;
        #2;
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (obs[k] !== 92'h0) begin
                n_fail++;
                $display("FAIL reset_init inst%0d: got %h expected 0", k, obs[k]);
            end
        end
        model_reset();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            p   = rand_pl();
            p.v = 1'b1;
            p.w = 1'b1;
            drive(p, 1'b0, 1'b0);
            tick();
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if (obs[k] !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL reset_fill inst%0d cyc%0d: got %h expected %h", k, c, obs[k], exp_vec(k));
                end
            end
        end
        // Asynchronous assertion away from any clock edge
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (obs[k] !== 92'h0) begin
                n_fail++;
                $display("FAIL reset_async inst%0d: got %h expected 0", k, obs[k]);
            end
        end
        n_checks++;
        if (g_dut[1].o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", g_dut[1].o_busy);
        end
        #2;
        rst = 1'b1;
    endtask

    task automatic test_latency();
        pl_t p;
        p   = rand_pl();
        p.v = 1'b1;
        p.w = 1'b1;
        p.d = 4'h5;
        p.a = 32'hDEADBEEF;
        drive(p, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (g_dut[3].o_sd[3:0] !== 4'h5) begin
            n_fail++;
            $display("FAIL latency_slot0_dest: got %h expected 5", g_dut[3].o_sd[3:0]);
        end
        for (int c = 1; c < 3; c++) begin
            p   = rand_pl();
            p.v = 1'b0;
            drive(p, 1'b0, 1'b0);
            tick();
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if (obs[k] !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL latency inst%0d cyc%0d: got %h expected %h", k, c, obs[k], exp_vec(k));
                end
            end
        end
        n_checks++;
        if ({g_dut[3].o_valid, g_dut[3].o_wb, g_dut[3].o_alu, g_dut[3].o_dest} !== {2'b11, 32'hDEADBEEF, 4'h5}) begin
            n_fail++;
            $display("FAIL latency_out: got v%b w%b %h d%h expected v1 w1 deadbeef d5",
                     g_dut[3].o_valid, g_dut[3].o_wb, g_dut[3].o_alu, g_dut[3].o_dest);
        end
    endtask

    task automatic test_freeze();
        pl_t pa, pb, pc, pd;
        pa = rand_pl(); pa.v = 1'b1; pa.a = 32'hAAAA0001;
        pb = rand_pl(); pb.v = 1'b1; pb.a = 32'hBBBB0002;
        pc = rand_pl(); pc.v = 1'b1; pc.a = 32'hCCCC0003;
        pd = rand_pl(); pd.a = 32'hDDDD0004;
        drive(pa, 1'b0, 1'b0); tick();
        drive(pb, 1'b0, 1'b0); tick();
        drive(pc, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (g_dut[1].o_alu !== 32'hAAAA0001) begin
                n_fail++;
                $display("FAIL freeze_hold cyc%0d: got %h expected aaaa0001", c, g_dut[1].o_alu);
            end
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if (obs[k] !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL freeze inst%0d cyc%0d: got %h expected %h", k, c, obs[k], exp_vec(k));
                end
            end
        end
        drive(pc, 1'b0, 1'b0); tick();
        n_checks++;
        if (g_dut[1].o_alu !== 32'hBBBB0002) begin
            n_fail++;
            $display("FAIL freeze_release_b: got %h expected bbbb0002", g_dut[1].o_alu);
        end
        drive(pd, 1'b0, 1'b0); tick();
        n_checks++;
        if (g_dut[1].o_alu !== 32'hCCCC0003) begin
            n_fail++;
            $display("FAIL freeze_release_c: got %h expected cccc0003", g_dut[1].o_alu);
        end
    endtask

    task automatic test_flush_all();
        pl_t p;
        for (int c = 0; c < 3; c++) begin
            p = rand_pl(); p.v = 1'b1; p.w = 1'b1;
            drive(p, 1'b0, 1'b0);
            tick();
        end
        n_checks++;
        if (g_dut[3].o_swb[2:0] !== 3'b111) begin
            n_fail++;
            $display("FAIL flush_all_pre: got %b expected 111", g_dut[3].o_swb);
        end
        p = rand_pl(); p.v = 1'b1; p.w = 1'b1;
        drive(p, 1'b0, 1'b1);
        tick();
        n_checks++;
        if ({g_dut[3].o_swb, g_dut[3].o_busy, g_dut[3].o_wb} !== 5'b0) begin
            n_fail++;
            $display("FAIL flush_all: got swb=%b busy=%b wb=%b expected 000/0/0",
                     g_dut[3].o_swb, g_dut[3].o_busy, g_dut[3].o_wb);
        end
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (obs[k] !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL flush_all inst%0d: got %h expected %h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_flush_freeze();
        pl_t p;
        p = rand_pl(); p.v = 1'b1; p.w = 1'b1; p.d = 4'h7;
        drive(p, 1'b0, 1'b0);
        tick();
        p = rand_pl(); p.v = 1'b1; p.w = 1'b1;
        drive(p, 1'b1, 1'b1);
        tick();
        n_checks++;
        if ({g_dut[2].o_swb, g_dut[2].o_sd[7:4]} !== {2'b10, 4'h7}) begin
            n_fail++;
            $display("FAIL flush_freeze: got swb=%b dest1=%h expected 10/7",
                     g_dut[2].o_swb, g_dut[2].o_sd[7:4]);
        end
        for (int k = 0; k < NI; k++) begin
            n_checks++;
            if (obs[k] !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL flush_freeze inst%0d: got %h expected %h", k, obs[k], exp_vec(k));
            end
        end
    endtask

    task automatic test_invalid();
        pl_t p;
        for (int c = 0; c < 2; c++) begin
            p = rand_pl(); p.v = 1'b0; p.w = 1'b1; p.m = (c == 0);
            drive(p, 1'b0, 1'b0);
            tick();
            n_checks++;
            if ({g_dut[0].o_wb, g_dut[0].o_swb, g_dut[0].o_mrd} !== {2'b00, p.m}) begin
                n_fail++;
                $display("FAIL invalid_in cyc%0d: got wb=%b swb=%b mrd=%b expected 0/0/%b",
                         c, g_dut[0].o_wb, g_dut[0].o_swb, g_dut[0].o_mrd, p.m);
            end
        end
    endtask

    task automatic test_random();
        pl_t p;
        for (int c = 0; c < 400; c++) begin
            p = rand_pl();
            drive(p, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
            tick();
            for (int k = 0; k < NI; k++) begin
                n_checks++;
                if (obs[k] !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL random inst%0d cyc%0d: got %h expected %h", k, c, obs[k], exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_freeze();
        test_flush_all();
        test_flush_freeze();
        test_invalid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
